// File: rtl/ifu_axil_rd_slave.sv
// ifu_axil_rd_slave
// AXI-lite read-only responder on the far end of the instruction-fetch
// read channel. Accepted fetch addresses are classified (OKAY / SLVERR /
// DECERR) and queued in a small request FIFO. A five-state sequencer then
// drains the queue one request at a time through a synchronous single-port
// SRAM and returns 64-bit beats strictly in acceptance order.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ifu_arvalid/arready    read address handshake
//   ifu_araddr             64-bit byte address of the fetch
//   ifu_rvalid/rready      read data handshake
//   ifu_rresp              00 OKAY, 10 SLVERR, 11 DECERR
//   ifu_rdata              64-bit read beat (zero for error beats)
//   mem_en, mem_addr       SRAM read strobe and word address
//   mem_rdata              SRAM data, valid the cycle after mem_en
//   pending_cnt            requests accepted whose beat is not yet taken
module ifu_axil_rd_slave #(
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int unsigned MEM_AW     = 16,
   parameter int unsigned FIFO_AW    = 2,
   parameter int unsigned RD_LATENCY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ifu_arvalid,
   output logic              ifu_arready,
   input  logic [63:0]       ifu_araddr,
   output logic              ifu_rvalid,
   input  logic              ifu_rready,
   output logic [1:0]        ifu_rresp,
   output logic [63:0]       ifu_rdata,
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [63:0]       mem_rdata,
   output logic [FIFO_AW:0]  pending_cnt
);

   localparam int unsigned DEPTH      = 1 << FIFO_AW;
   localparam logic [63:0] WINDOW_END = BASE_ADDR + (64'd1 << (MEM_AW + 3));
   localparam logic [3:0]  LAT        = 4'(RD_LATENCY);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {IDLE, WAIT, ISSUE, CAPT, RESP} FetchState;

   FetchState         state_q;
   logic [MEM_AW+1:0] fifoMem_q [DEPTH];
   logic [FIFO_AW-1:0] wrPtr_q;
   logic [FIFO_AW-1:0] rdPtr_q;
   logic [FIFO_AW:0]  fifoCount_q;
   logic [FIFO_AW:0]  fifoCount_d;
   logic [FIFO_AW:0]  pendingCnt_q;
   logic [FIFO_AW:0]  pendingCnt_d;
   logic              arReady_q;
   logic [3:0]        waitCnt_q;
   logic [1:0]        curErr_q;
   logic              memEn_q;
   logic [MEM_AW-1:0] memAddr_q;
   logic              rValid_q;
   logic [1:0]        rResp_q;
   logic [63:0]       rData_q;

   logic              arHandshake;
   logic              rHandshake;
   logic              fifoPop;
   logic              fifoEmpty;
   logic              headOk;
   logic [1:0]        reqErr;
   logic [1:0]        headErr;
   logic [MEM_AW-1:0] reqWordAddr;
   logic [MEM_AW-1:0] headAddr;

   // Classify the incoming address as it is presented. Decode errors
   // (outside the SRAM window) win over misalignment, and the word address
   // is simply the window offset in 8-byte units.
   always_comb begin
      if ((ifu_araddr < BASE_ADDR) || (ifu_araddr >= WINDOW_END)) begin
         reqErr = RESP_DECERR;
      end else if (ifu_araddr[2:0] != 3'b000) begin
         reqErr = RESP_SLVERR;
      end else begin
         reqErr = RESP_OKAY;
      end
      reqWordAddr = MEM_AW'((ifu_araddr - BASE_ADDR) >> 3);
   end

   assign arHandshake = ifu_arvalid & arReady_q;
   assign rHandshake  = rValid_q & ifu_rready;
   assign fifoPop     = (state_q == ISSUE);
   assign fifoEmpty   = (fifoCount_q == '0);
   assign headErr     = fifoMem_q[rdPtr_q][MEM_AW+1:MEM_AW];
   assign headAddr    = fifoMem_q[rdPtr_q][MEM_AW-1:0];
   assign headOk      = (headErr == RESP_OKAY);

   // Next FIFO occupancy and next outstanding-request count. A push and a
   // pop (or an ar and an r handshake) in the same cycle cancel out.
   always_comb begin
      fifoCount_d = fifoCount_q;
      if (arHandshake && !fifoPop) begin
         fifoCount_d = fifoCount_q + (FIFO_AW+1)'(1);
      end else if (!arHandshake && fifoPop) begin
         fifoCount_d = fifoCount_q - (FIFO_AW+1)'(1);
      end

      pendingCnt_d = pendingCnt_q;
      if (arHandshake && !rHandshake) begin
         pendingCnt_d = pendingCnt_q + (FIFO_AW+1)'(1);
      end else if (!arHandshake && rHandshake) begin
         pendingCnt_d = pendingCnt_q - (FIFO_AW+1)'(1);
      end
   end

   // Request storage needs no reset: an entry is only ever read after it
   // has been written, as tracked by the pointers and count below.
   always_ff @(posedge clk) begin
      if (arHandshake) begin
         fifoMem_q[wrPtr_q] <= {reqErr, reqWordAddr};
      end
   end

   // FIFO pointers, counters and the registered arready. arready follows
   // the registered occupancy, so a slot freed by a pop only becomes
   // visible to the initiator in the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         fifoCount_q  <= '0;
         pendingCnt_q <= '0;
         arReady_q    <= 1'b0;
      end else begin
         if (arHandshake) begin
            wrPtr_q <= wrPtr_q + FIFO_AW'(1);
         end
         if (fifoPop) begin
            rdPtr_q <= rdPtr_q + FIFO_AW'(1);
         end
         fifoCount_q  <= fifoCount_d;
         pendingCnt_q <= pendingCnt_d;
         arReady_q    <= (fifoCount_d != (FIFO_AW+1)'(DEPTH));
      end
   end

   // Request sequencer. mem_en is registered, so it is raised on the edge
   // that enters ISSUE using the FIFO head at that moment; the head is then
   // popped at the end of ISSUE. Error requests walk through exactly the
   // same states so their beats have the same timing as OKAY beats, they
   // simply never strobe the SRAM and return zero data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         curErr_q  <= RESP_OKAY;
         memEn_q   <= 1'b0;
         memAddr_q <= '0;
         rValid_q  <= 1'b0;
         rResp_q   <= RESP_OKAY;
         rData_q   <= '0;
      end else begin
         memEn_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifoEmpty) begin
                  if (LAT != 4'd0) begin
                     state_q   <= WAIT;
                     waitCnt_q <= LAT;
                  end else begin
                     state_q   <= ISSUE;
                     memEn_q   <= headOk;
                     memAddr_q <= headAddr;
                  end
               end
            end
            WAIT: begin
               waitCnt_q <= waitCnt_q - 4'd1;
               if (waitCnt_q == 4'd1) begin
                  state_q   <= ISSUE;
                  memEn_q   <= headOk;
                  memAddr_q <= headAddr;
               end
            end
            ISSUE: begin
               curErr_q <= headErr;
               state_q  <= CAPT;
            end
            CAPT: begin
               rData_q  <= (curErr_q == RESP_OKAY) ? mem_rdata : 64'h0;
               rResp_q  <= curErr_q;
               rValid_q <= 1'b1;
               state_q  <= RESP;
            end
            RESP: begin
               if (ifu_rready) begin
                  rValid_q <= 1'b0;
                  if (fifoEmpty) begin
                     state_q <= IDLE;
                  end else if (LAT != 4'd0) begin
                     state_q   <= WAIT;
                     waitCnt_q <= LAT;
                  end else begin
                     state_q   <= ISSUE;
                     memEn_q   <= headOk;
                     memAddr_q <= headAddr;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ifu_arready = arReady_q;
   assign ifu_rvalid  = rValid_q;
   assign ifu_rresp   = rResp_q;
   assign ifu_rdata   = rData_q;
   assign mem_en      = memEn_q;
   assign mem_addr    = memAddr_q;
   assign pending_cnt = pendingCnt_q;

endmodule

// File: tb/tb_ifu_axil_rd_slave.sv
// tb_ifu_axil_rd_slave
// Bench for ifu_axil_rd_slave. One instance runs with RD_LATENCY=0 and is
// followed by a scoreboard that predicts every beat from the address rules
// and an SRAM content function; a second instance with RD_LATENCY=3 is
// used for latency measurements. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_ifu_axil_rd_slave;

   localparam logic [63:0] BASE    = 64'h8000_0000;
   localparam int          MEM_AW  = 16;
   localparam int          FIFO_AW = 2;
   localparam int          DEPTH   = 4;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        arvalid, arready, rvalid, rready, memEn;
   logic [63:0] araddr, rdata, memRdata;
   logic [1:0]  rresp;
   logic [15:0] memAddr;
   logic [2:0]  pendingCnt;

   logic        bArvalid, bArready, bRvalid, bRready, bMemEn;
   logic [63:0] bAraddr, bRdata, bMemRdata;
   logic [1:0]  bRresp;
   logic [15:0] bMemAddr;
   logic [2:0]  bPendingCnt;

   int          checkCount = 0;
   int          failCount  = 0;

   logic [65:0] expQ[$];
   logic [15:0] memAddrQ[$];
   int          beatEdges[$];
   int          accepted = 0;
   int          returned = 0;
   int          edgeCnt = 0;
   int          arEdge = 0;
   int          rvEdge = 0;
   int          memEnCount = 0;
   int          peakPending = 0;
   bit          monEn = 1'b0;
   bit          stallSeen = 1'b0;
   bit          prevRvalid = 1'b0;
   logic [63:0] heldData;
   logic [1:0]  heldResp;

   always #5 clk = ~clk;

   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   ifu_axil_rd_slave #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW), .FIFO_AW(FIFO_AW), .RD_LATENCY(0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_arvalid(arvalid), .ifu_arready(arready), .ifu_araddr(araddr),
      .ifu_rvalid(rvalid), .ifu_rready(rready), .ifu_rresp(rresp), .ifu_rdata(rdata),
      .mem_en(memEn), .mem_addr(memAddr), .mem_rdata(memRdata),
      .pending_cnt(pendingCnt)
   );

   ifu_axil_rd_slave #(.BASE_ADDR(BASE), .MEM_AW(MEM_AW), .FIFO_AW(FIFO_AW), .RD_LATENCY(3)) u_dut_lat3 (
      .clk(clk), .rst_n(rst_n),
      .ifu_arvalid(bArvalid), .ifu_arready(bArready), .ifu_araddr(bAraddr),
      .ifu_rvalid(bRvalid), .ifu_rready(bRready), .ifu_rresp(bRresp), .ifu_rdata(bRdata),
      .mem_en(bMemEn), .mem_addr(bMemAddr), .mem_rdata(bMemRdata),
      .pending_cnt(bPendingCnt)
   );

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // SRAM contents: word 0 is a fixed pattern, all others derived from the address.
   function automatic logic [63:0] memWord(input logic [15:0] a);
      if (a == 16'h0) return 64'h0123_4567_89ab_cdef;
      return {a ^ 16'hA5C3, a, ~a, a * 16'h9E37};
   endfunction

   // Expected beat {rresp, rdata} for an address, straight from the address rules.
   function automatic logic [65:0] expectBeat(input logic [63:0] addr);
      logic [63:0] top;
      top = BASE + (64'd1 << (MEM_AW + 3));
      if (addr < BASE || addr >= top) return {2'b11, 64'h0};
      if (addr % 8 != 0) return {2'b10, 64'h0};
      return {2'b00, memWord(16'((addr - BASE) / 8))};
   endfunction

   // SRAM models: data for the strobed word one cycle later, garbage otherwise.
   always @(posedge clk) begin
      memRdata  <= memEn  ? memWord(memAddr)  : {$urandom, $urandom};
      bMemRdata <= bMemEn ? memWord(bMemAddr) : {$urandom, $urandom};
   end

   // Scoreboard for the latency-0 instance. Checks run against the model
   // state from earlier edges; handshakes seen here take effect on the next edge.
   always @(negedge clk) begin
      logic [65:0] e;
      logic [63:0] a;
      int outstanding;
      if (rst_n && monEn) begin
         outstanding = accepted - returned;
         checkOutput("pending_cnt", 64'(pendingCnt), 64'(outstanding));
         if (int'(pendingCnt) > peakPending) peakPending = int'(pendingCnt);
         if (outstanding < DEPTH) checkOutput("arready_room", 64'(arready), 64'(1));
         if (outstanding > DEPTH) checkOutput("arready_full", 64'(arready), 64'(0));
         if (stallSeen) begin
            checkOutput("rvalid_hold", 64'(rvalid), 64'(1));
            checkOutput("rdata_hold", rdata, heldData);
            checkOutput("rresp_hold", 64'(rresp), 64'(heldResp));
         end
         stallSeen = rvalid && !rready;
         heldData  = rdata;
         heldResp  = rresp;
         if (rvalid && !prevRvalid) rvEdge = edgeCnt;
         prevRvalid = rvalid;
         if (memEn) begin
            memEnCount++;
            if (memAddrQ.size() == 0) checkOutput("mem_en_spurious", 64'(memEn), 64'(0));
            else checkOutput("mem_addr", 64'(memAddr), 64'(memAddrQ.pop_front()));
         end
         if (arvalid && arready) begin
            a = araddr;
            e = expectBeat(a);
            expQ.push_back(e);
            if (e[65:64] == 2'b00) memAddrQ.push_back(16'((a - BASE) / 8));
            arEdge = edgeCnt + 1;
            accepted++;
         end
         if (rvalid && rready) begin
            if (expQ.size() == 0) begin
               checkOutput("beat_spurious", 64'(rvalid), 64'(0));
            end else begin
               e = expQ.pop_front();
               checkOutput("rresp", 64'(rresp), 64'(e[65:64]));
               checkOutput("rdata", rdata, e[63:0]);
            end
            beatEdges.push_back(edgeCnt + 1);
            returned++;
         end
      end
   end

   // Asserts reset, checks the reset values, clears the model, releases.
   task automatic applyReset(input int cycles);
      monEn   = 1'b0;
      rst_n   = 1'b0;
      arvalid = 1'b0; rready = 1'b0; araddr = '0;
      bArvalid = 1'b0; bRready = 1'b0; bAraddr = '0;
      #2;
      checkOutput("rst_arready", 64'(arready), 64'(0));
      checkOutput("rst_rvalid", 64'(rvalid), 64'(0));
      checkOutput("rst_rresp", 64'(rresp), 64'(0));
      checkOutput("rst_rdata", rdata, 64'h0);
      checkOutput("rst_mem_en", 64'(memEn), 64'(0));
      checkOutput("rst_pending", 64'(pendingCnt), 64'(0));
      expQ.delete(); memAddrQ.delete(); beatEdges.delete();
      accepted = 0; returned = 0; stallSeen = 1'b0; prevRvalid = 1'b0;
      repeat (cycles) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("arready_after_reset", 64'(arready), 64'(1));
      monEn = 1'b1;
   endtask

   // Presents one address and waits (bounded) for its acceptance.
   task automatic sendAr(input logic [63:0] addr, input bit keepValid);
      int waitCycles;
      waitCycles = 0;
      araddr = addr; arvalid = 1'b1;
      @(negedge clk);
      while (!arready && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("ar_accept", 64'(arready), 64'(1));
      @(posedge clk); #1;
      if (!keepValid) arvalid = 1'b0;
   endtask

   // Waits (bounded) until every accepted request has returned its beat.
   task automatic drain(input int budget);
      int n;
      n = 0;
      while (accepted != returned && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain", 64'(accepted - returned), 64'(0));
      @(posedge clk); #1;
   endtask

   // One isolated read with rready high; checks latency and SRAM strobes.
   task automatic singleRead(input logic [63:0] addr, input int expLat);
      int enBefore;
      logic [65:0] e;
      enBefore = memEnCount;
      e = expectBeat(addr);
      rready = 1'b1;
      sendAr(addr, 1'b0);
      drain(40);
      checkOutput("latency", 64'(rvEdge - arEdge), 64'(expLat));
      checkOutput("mem_en_pulses", 64'(memEnCount - enBefore), (e[65:64] == 2'b00) ? 64'(1) : 64'(0));
   endtask

   // Latency measurement on the RD_LATENCY=3 instance.
   task automatic latRead(input logic [63:0] addr);
      int k;
      logic [65:0] e;
      e = expectBeat(addr);
      bRready = 1'b1; bAraddr = addr; bArvalid = 1'b1;
      @(negedge clk);
      checkOutput("lat3_arready", 64'(bArready), 64'(1));
      @(posedge clk); #1;
      bArvalid = 1'b0;
      k = 0;
      while (k < 30) begin
         @(negedge clk);
         if (bRvalid) break;
         k++;
      end
      checkOutput("lat3_latency", 64'(k), 64'(6));
      checkOutput("lat3_pending", 64'(bPendingCnt), 64'(1));
      checkOutput("lat3_rresp", 64'(bRresp), 64'(e[65:64]));
      checkOutput("lat3_rdata", bRdata, e[63:0]);
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] randAddr();
      case ($urandom_range(0, 5))
         0, 1, 2: return BASE + 64'(8 * $urandom_range(0, 65535));
         3:       return BASE + 64'(8 * $urandom_range(0, 65535)) + 64'($urandom_range(1, 7));
         4:       return BASE - 64'($urandom_range(1, 400));
         default: return BASE + (64'd1 << (MEM_AW + 3)) + 64'($urandom_range(0, 400));
      endcase
   endfunction

   // Random traffic with random backpressure, then a full drain.
   task automatic applyStimulus(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         arvalid = ($urandom_range(0, 2) != 0);
         araddr  = randAddr();
         rready  = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      drain(200);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, %0d checks so far", checkCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int accBase;
      rst_n = 1'b1;
      arvalid = 1'b0; rready = 1'b0; araddr = '0;
      bArvalid = 1'b0; bRready = 1'b0; bAraddr = '0;
      #1;
      applyReset(3);

      $display("[TB] latency-3 instance");
      latRead(BASE + 64'h8);
      latRead(BASE + 64'h4);

      $display("[TB] single reads and error responses");
      singleRead(64'h8000_0000, 3);
      singleRead(64'h7fff_fff8, 3);
      singleRead(64'h8000_0004, 3);
      singleRead(64'h7fff_fffc, 3);
      singleRead(64'h8008_0000, 3);
      singleRead(64'h8007_fff8, 3);

      $display("[TB] backpressure with a full queue");
      rready = 1'b0;
      peakPending = 0;
      accBase = accepted;
      fork
         begin
            for (int k = 0; k < 6; k++) sendAr(BASE + 64'(8 * k), 1'b1);
            arvalid = 1'b0;
         end
         begin
            repeat (12) @(posedge clk);
            #1;
            checkOutput("peak_pending", 64'(peakPending), 64'(5));
            checkOutput("accepts_while_stalled", 64'(accepted - accBase), 64'(5));
            rready = 1'b1;
         end
      join
      drain(80);

      $display("[TB] R channel stall");
      rready = 1'b0;
      sendAr(BASE + 64'h40, 1'b0);
      for (int k = 0; k < 20 && !rvalid; k++) @(negedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("stall_pending", 64'(pendingCnt), 64'(1));
      @(posedge clk); #1;
      rready = 1'b1;
      drain(20);

      $display("[TB] back-to-back beat spacing");
      beatEdges.delete();
      rready = 1'b1;
      for (int k = 0; k < 4; k++) sendAr(BASE + 64'(8 * (10 + k)), 1'b1);
      arvalid = 1'b0;
      drain(60);
      checkOutput("beat_count", 64'(beatEdges.size()), 64'(4));
      for (int k = 1; k < beatEdges.size(); k++)
         checkOutput("beat_spacing", 64'(beatEdges[k] - beatEdges[k-1]), 64'(3));

      $display("[TB] random traffic");
      applyStimulus(400);

      $display("[TB] reset mid-operation");
      rready = 1'b0;
      for (int k = 0; k < 3; k++) sendAr(BASE + 64'(8 * (20 + k)), 1'b1);
      arvalid = 1'b0;
      applyReset(2);
      singleRead(BASE + 64'h28, 3);
      repeat (10) @(posedge clk);
      checkOutput("no_stale_beats", 64'(returned), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
